// File: rtl/sync_fifo_gen_if.sv
// Handshake and status bundle for sync_fifo_gen.
// The master side drives requests and data; the slave side is the FIFO itself.
interface sync_fifo_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);

  logic              flush;
  logic              err_clr;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush,
    output err_clr,
    output wr_en,
    output din,
    output rd_en,
    input  dout,
    input  valid,
    input  empty,
    input  full,
    input  almost_empty,
    input  almost_full,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  flush,
    input  err_clr,
    input  wr_en,
    input  din,
    input  rd_en,
    output dout,
    output valid,
    output empty,
    output full,
    output almost_empty,
    output almost_full,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with thresholds, sticky error flags, flush
// and an optional first-word-fall-through read port.
module sync_fifo_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned AF_LEVEL = (2 ** ADDR_W) - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input logic            clk50M,
  input logic            rst,
  sync_fifo_gen_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   CntFull = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PtrOne  = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   AfLevel = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0]   AeLevel = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic empty, full;
  logic wr_acc, rd_acc;
  logic ovf_set, unf_set;

  // Acceptance is qualified only by the registered count, never by same-cycle traffic.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntFull);
    wr_acc  = bus.wr_en & ~full & ~bus.flush;
    rd_acc  = bus.rd_en & ~empty & ~bus.flush;
    ovf_set = bus.wr_en & full & ~bus.flush;
    unf_set = bus.rd_en & empty & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      // A new error event wins over a clear arriving in the same cycle.
      if (ovf_set) begin
        overflow_d = 1'b1;
      end else if (bus.err_clr) begin
        overflow_d = 1'b0;
      end
      if (unf_set) begin
        underflow_d = 1'b1;
      end else if (bus.err_clr) begin
        underflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not cleared by reset or flush.
  always_ff @(posedge clk50M) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  if (FWFT) begin : g_fwft
    assign bus.dout  = mem_q[rd_ptr_q];
    assign bus.valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    always_ff @(posedge clk50M) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end

  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= AeLevel);
  assign bus.almost_full  = (count_q >= AfLevel);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
